// File: rtl/mdu_seq_if.sv
// mdu_seq_if: issue and result bus between the core and the multiply/divide unit
interface mdu_seq_if #(parameter int WIDTH = 32) ();
    logic             start;
    logic [1:0]       func;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;
    modport master (output start, func, inA, inB, input busy, done, hi, lo, div_zero);
    modport slave (input start, func, inA, inB, output busy, done, hi, lo, div_zero);
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle on magnitudes, sign fixed at the end
module mdu_seq #(parameter int WIDTH = 32) (
    input logic clk,
    input logic rst_n,
    mdu_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
    localparam int CW = $clog2(WIDTH);
    state_t             state;
    logic [1:0]         fn;
    logic               sa, sb;
    logic [WIDTH-1:0]   a_raw, b_mag, a_mag, rem_sub, quo, rem;
    logic [2*WIDTH-1:0] acc, acc_next, prod;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     add_sum, rem_try;
    logic               neg_a, neg_b, fits, flip;
    // acc holds {upper partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        neg_a = ~bus.func[0] & bus.inA[WIDTH-1];
        neg_b = ~bus.func[0] & bus.inB[WIDTH-1];
        a_mag = neg_a ? -bus.inA : bus.inA;
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
        rem_try = acc[2*WIDTH-1:WIDTH-1];
        rem_sub = rem_try[WIDTH-1:0] - b_mag;
        fits = rem_try >= {1'b0, b_mag};
        acc_next = fn[1] ? {fits ? rem_sub : rem_try[WIDTH-1:0], acc[WIDTH-2:0], fits}
                         : {add_sum, acc[WIDTH-1:1]};
        flip = ~fn[0] & (sa ^ sb);
        prod = flip ? -acc : acc;
        quo = flip ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem = (~fn[0] & sa) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.hi <= '0;
            bus.lo <= '0;
            bus.div_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    fn <= bus.func;
                    sa <= neg_a;
                    sb <= neg_b;
                    a_raw <= bus.inA;
                    b_mag <= neg_b ? -bus.inB : bus.inB;
                    acc <= {{WIDTH{1'b0}}, a_mag};
                    cnt <= '0;
                    bus.div_zero <= 1'b0;
                    bus.busy <= 1'b1;
                    state <= CALC;
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    state <= (cnt == CW'(WIDTH - 1)) ? SIGN : CALC;
                end
                SIGN: begin
                    // divide by zero reports the dividend unchanged and an all-ones quotient
                    if (fn[1] && b_mag == '0) begin
                        bus.hi <= a_raw;
                        bus.lo <= '1;
                        bus.div_zero <= 1'b1;
                    end else begin
                        bus.hi <= fn[1] ? rem : prod[2*WIDTH-1:WIDTH];
                        bus.lo <= fn[1] ? quo : prod[WIDTH-1:0];
                    end
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state <= DONE;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed vectors against an arithmetic reference model with per-cycle output checking
module tb_mdu_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_seq_if #(.WIDTH(32)) bus ();
    mdu_seq #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int vec = 0;
    int err = 0;
    int e = 0;
    int t_acc = 0;
    bit pending = 1'b0;
    logic [63:0] res = '0;
    logic res_dz = 1'b0;
    logic [31:0] exp_hi = '0, exp_lo = '0;
    logic exp_dz = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;

    // {hi, lo} straight from the instruction-set definition of each operation
    function automatic logic [63:0] golden(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (f[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
        case (f)
            2'b00: return sa * sb;
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: return {a % b, a / b};
        endcase
    endfunction

    // timeline model: accept at edge k, done after edge k+33, start ignored until edge k+35
    always @(posedge clk) begin
        e <= e + 1;
        if (!rst_n) begin
            pending <= 1'b0;
            exp_busy <= 1'b0;
            exp_done <= 1'b0;
            exp_hi <= '0;
            exp_lo <= '0;
            exp_dz <= 1'b0;
        end else if (bus.start && (!pending || e >= t_acc + 35)) begin
            pending <= 1'b1;
            t_acc <= e;
            res <= golden(bus.func, bus.inA, bus.inB);
            res_dz <= bus.func[1] && bus.inB == 32'd0;
            exp_busy <= 1'b1;
            exp_done <= 1'b0;
            exp_dz <= 1'b0;
        end else begin
            exp_busy <= pending && e < t_acc + 33;
            exp_done <= pending && e == t_acc + 33;
            if (pending && e == t_acc + 33) begin
                exp_hi <= res[63:32];
                exp_lo <= res[31:0];
                exp_dz <= res_dz;
            end
        end
    end

    always @(negedge clk) begin
        if (e > 0) begin
            vec++;
            if ({bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo} !== {exp_busy, exp_done, exp_dz, exp_hi, exp_lo}) begin
                err++;
                $display("FAIL cycle %0d: busy/done/dz/hi/lo got %b %b %b %h %h want %b %b %b %h %h", e,
                         bus.busy, bus.done, bus.div_zero, bus.hi, bus.lo, exp_busy, exp_done, exp_dz, exp_hi, exp_lo);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vec++;
        if (got !== want) begin
            err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // issue at the current negedge; poke re-pulses start with new operands mid-operation
    task automatic run(input string name, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit lit, input logic [63:0] want, input logic want_dz, input bit poke);
        int n = 0;
        int nb = 0;
        bus.start = 1'b1;
        bus.func = f;
        bus.inA = a;
        bus.inB = b;
        do begin
            @(negedge clk);
            n++;
            bus.start = poke && (n == 5 || n == 32);
            bus.inA = poke ? 32'd9 : ~a;
            bus.inB = poke ? 32'd9 : ~b;
            bus.func = poke ? f : ~f;
            if (bus.busy) nb++;
        end while (!bus.done && n < 40);
        if (!bus.done) begin
            vec++;
            err++;
            $display("FAIL %s: no done within 40 cycles", name);
            return;
        end
        check({name, " latency"}, 64'(n), 64'd34);
        check({name, " busy cycles"}, 64'(nb), 64'd33);
        if (lit) begin
            check({name, " hi:lo"}, {bus.hi, bus.lo}, want);
            check({name, " div_zero"}, 64'(bus.div_zero), 64'(want_dz));
            check({name, " model"}, golden(f, a, b), want);
        end
        @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.func = 2'b00;
        bus.inA = '0;
        bus.inB = '0;
        repeat (3) @(negedge clk);
        check("reset outputs", {29'd0, bus.busy, bus.done, bus.div_zero, bus.hi}, 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001, 1'b0, 0);
        run("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 1, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 0);
        run("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 0);
        run("divu", 2'b11, 32'd100, 32'd7, 1, {32'd2, 32'd14}, 1'b0, 0);
        run("divu_zero", 2'b11, 32'h64, 32'd0, 1, {32'h64, 32'hFFFF_FFFF}, 1'b1, 0);
        run("multu_after_dz", 2'b01, 32'd2, 32'd3, 1, 64'd6, 1'b0, 0);
        run("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, {32'd0, 32'h8000_0000}, 1'b0, 0);
        run("mult_poke", 2'b00, 32'd2, 32'd2, 1, 64'd4, 1'b0, 1);
        run("div_zero_signed", 2'b10, 32'hFFFF_FFF9, 32'd0, 1, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b1, 0);
        run("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 1, 64'h4000_0000_0000_0000, 1'b0, 0);
        run("div_pos_neg", 2'b10, 32'd7, 32'hFFFF_FFFE, 1, {32'd1, 32'hFFFF_FFFD}, 1'b0, 0);
        run("div_neg_neg", 2'b10, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 1, {32'hFFFF_FFFE, 32'd2}, 1'b0, 0);
        run("multu_mix", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 0, 64'd0, 1'b0, 0);
        run("divu_big", 2'b11, 32'hFFFF_FFFF, 32'h0001_0001, 0, 64'd0, 1'b0, 0);
        bus.start = 1'b1;
        bus.func = 2'b10;
        bus.inA = 32'd100;
        bus.inB = 32'd7;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("midop reset", {bus.busy, bus.done, 30'd0, bus.hi | bus.lo}, 64'd0);
        rst_n = 1'b1;
        run("after_reset", 2'b11, 32'd100, 32'd7, 1, {32'd2, 32'd14}, 1'b0, 0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
